fire_burst_trap: RTL and testbench

//  Fire-code burst-error trapping and correction stage for a shortened (N,K) Fire code.

---
 rtl/fire_pkg.sv | 37 +++
 rtl/fire_burst_trap_if.sv | 28 ++
 rtl/fire_gf_mulx.sv | 13 +
 rtl/fire_burst_trap.sv | 167 ++++++++++++++++
 tb/tb_fire_burst_trap.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fire_pkg.sv
// Shared definitions for the Fire-code burst trapping slice.
// Holds the code parameters, status and FSM encodings, and a burst-degree helper.
package fire_pkg;

  localparam int unsigned N  = 64;   // codeword length
  localparam int unsigned K  = 40;   // information bits (N-K = C+M)
  localparam int unsigned M  = 9;    // degree of p(x)
  localparam int unsigned C  = 15;   // degree of the x^C+1 factor
  localparam int unsigned B  = 8;    // correctable burst length
  localparam logic [M-1:0] P_LOW = 9'h011;  // p(x) = x^9 + x^4 + 1
  localparam int unsigned JW = 7;    // counter width, holds 0..N

  typedef enum logic [1:0] {
    ST_NOERR  = 2'd0,
    ST_CORR   = 2'd1,
    ST_UNCORR = 2'd2
  } status_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_SHIFT,
    S_WAIT,
    S_TRAP,
    S_LOCATE,
    S_DONE
  } state_t;

  // Index of the highest set bit of a burst pattern (0 for an all-zero pattern).
  function automatic logic [3:0] burst_deg(input logic [B-1:0] b);
    burst_deg = '0;
    for (int unsigned i = 0; i < B; i++) begin
      if (b[i]) burst_deg = 4'(i);
    end
  endfunction

endpackage

// File: rtl/fire_burst_trap_if.sv
// Stream interface of the burst-trapping stage.
//   in_valid/in_ready/cw_in : codeword offer (producer -> stage)
//   out_valid/out_ready     : result handshake (stage -> consumer)
//   cw_out/status/err_pos   : corrected word, NOERR/CORR/UNCORR, burst start index
// master = producer/consumer side, slave = the stage.
interface fire_burst_trap_if;
  import fire_pkg::*;

  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] cw_in;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] cw_out;
  logic [1:0]   status;
  logic [5:0]   err_pos;

  modport master (
    output in_valid, cw_in, out_ready,
    input  in_ready, out_valid, cw_out, status, err_pos
  );

  modport slave (
    input  in_valid, cw_in, out_ready,
    output in_ready, out_valid, cw_out, status, err_pos
  );

endinterface

// File: rtl/fire_gf_mulx.sv
// One multiply-by-x step in GF(2)[x] / p(x).
//   a : operand, bit k = coefficient of x^k
//   y : a*x mod p(x)
module fire_gf_mulx
  import fire_pkg::*;
(
  input  logic [M-1:0] a,
  output logic [M-1:0] y
);

  always_comb y = {a[M-2:0], 1'b0} ^ (a[M-1] ? P_LOW : '0);

endmodule

// File: rtl/fire_burst_trap.sv
// Fire-code burst-error trapping and correction stage.
// Drives an external p(x) syndrome stage (p_clr/p_shift/p_data), forms the
// x^C+1 remainder itself, traps a burst of length <= B, locates it and
// emits the corrected word.
//   clk, rst_n          : clock, async active-low reset
//   bus (slave)         : codeword in / result out handshakes
//   p_clr, p_shift      : clear and shift strobes to the syndrome stage
//   p_data              : latched codeword feeding the syndrome stage
//   p_count, syn_p      : syndrome stage bit count and v(x) mod p(x)
module fire_burst_trap
  import fire_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  fire_burst_trap_if.slave bus,
  output logic             p_clr,
  output logic             p_shift,
  output logic [N-1:0]     p_data,
  input  logic [10:0]      p_count,
  input  logic [M-1:0]     syn_p
);

  state_t        state, state_n;
  logic [JW-1:0] cnt;        // bit index in SHIFT, j in LOCATE
  logic [3:0]    r;          // trap rotation
  logic [3:0]    jm;         // j mod C, wraps instead of dividing
  logic [C-1:0]  s_c;
  logic [C-1:0]  t;
  logic [M-1:0]  syn_q;
  logic [M-1:0]  tj;
  logic [M-1:0]  tj_x;
  logic [B-1:0]  bpat;
  logic [N-1:0]  cw_q;
  status_t       status_q;
  logic [5:0]    err_q;
  logic          in_ready_q, out_valid_q;
  logic          in_ready_d, out_valid_d, p_clr_d, p_shift_d;

  logic          syn_ok, trap_hit, loc_hit;
  logic [7:0]    j_end;
  logic [5:0]    bit_idx;

  fire_gf_mulx u_mulx (.a(tj), .y(tj_x));

  always_comb begin
    syn_ok   = (p_count == 11'(N));
    trap_hit = (t[C-1:B] == '0) && t[0];
    j_end    = {1'b0, cnt} + {4'b0, burst_deg(bpat)};
    loc_hit  = (jm == r) && (tj == syn_q) && (j_end <= 8'(N-1));
    bit_idx  = 6'(N-1) - cnt[5:0];
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:   if (bus.in_valid) state_n = S_CLR;
      S_CLR:    state_n = S_SHIFT;
      S_SHIFT:  if (cnt == JW'(N-1)) state_n = S_WAIT;
      S_WAIT:   if (syn_ok) state_n = (s_c != '0 && syn_p != '0) ? S_TRAP : S_DONE;
      S_TRAP: begin
        if (trap_hit)             state_n = S_LOCATE;
        else if (r == 4'(C-1))    state_n = S_DONE;
      end
      S_LOCATE: if (loc_hit || cnt == JW'(N-1)) state_n = S_DONE;
      S_DONE:   if (bus.out_ready) state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  // Outputs decoded from the next state so the registered strobes line up with the state
  always_comb begin
    in_ready_d  = (state_n == S_IDLE);
    p_clr_d     = (state_n == S_CLR);
    p_shift_d   = (state_n == S_SHIFT);
    out_valid_d = (state_n == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_q  <= 1'b1;
      p_clr       <= 1'b0;
      p_shift     <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      in_ready_q  <= in_ready_d;
      p_clr       <= p_clr_d;
      p_shift     <= p_shift_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_data   <= '0;
      cnt      <= '0;
      r        <= '0;
      jm       <= '0;
      s_c      <= '0;
      t        <= '0;
      syn_q    <= '0;
      tj       <= '0;
      bpat     <= '0;
      cw_q     <= '0;
      status_q <= ST_NOERR;
      err_q    <= '0;
    end else begin
      case (state)
        S_IDLE: if (bus.in_valid) begin
          p_data <= bus.cw_in;
          s_c    <= '0;
        end
        S_CLR: cnt <= '0;
        S_SHIFT: begin
          s_c <= {s_c[C-2:0], s_c[C-1]} ^ {{(C-1){1'b0}}, p_data[bit_idx]};
          cnt <= cnt + 1'b1;
        end
        S_WAIT: if (syn_ok) begin
          // Provisional verdict; CORR overwrites it only if LOCATE finds the burst
          syn_q    <= syn_p;
          t        <= s_c;
          r        <= '0;
          cw_q     <= p_data;
          err_q    <= '0;
          status_q <= (s_c == '0 && syn_p == '0) ? ST_NOERR : ST_UNCORR;
        end
        S_TRAP: begin
          if (trap_hit) begin
            bpat <= t[B-1:0];
            tj   <= {{(M-B){1'b0}}, t[B-1:0]};
            cnt  <= '0;
            jm   <= '0;
          end else begin
            t <= {t[0], t[C-1:1]};
            r <= r + 1'b1;
          end
        end
        S_LOCATE: begin
          if (loc_hit) begin
            cw_q     <= p_data ^ ({{(N-B){1'b0}}, bpat} << cnt);
            status_q <= ST_CORR;
            err_q    <= cnt[5:0];
          end else begin
            cnt <= cnt + 1'b1;
            jm  <= (jm == 4'(C-1)) ? '0 : jm + 1'b1;
            tj  <= tj_x;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.cw_out    = cw_q;
  assign bus.status    = status_q;
  assign bus.err_pos   = err_q;

endmodule

// File: tb/tb_fire_burst_trap.sv
// Testbench for fire_burst_trap paired with a behavioural p(x) syndrome stage.
// Expected results come from a polynomial-division model that searches for a
// burst e(x) = b(x)*x^j with v(x) == e(x) mod g(x).
module tb_fire_burst_trap;
  import fire_pkg::*;

  localparam logic [1:0] NOERR = 2'd0, CORR = 2'd1, UNCORR = 2'd2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         p_clr, p_shift;
  logic [N-1:0] p_data;
  logic [10:0]  p_count = '0;
  logic [M-1:0] syn_p = '0;

  int n_cmp = 0;
  int n_bad = 0;

  logic [63:0] CX, PX, GX;

  fire_burst_trap_if bus ();

  fire_burst_trap dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus),
    .p_clr  (p_clr),
    .p_shift(p_shift),
    .p_data (p_data),
    .p_count(p_count),
    .syn_p  (syn_p)
  );

  always #5 clk = ~clk;

  // Syndrome stage: Horner evaluation of v(x) mod p(x), MSB first
  always @(posedge clk) begin
    if (p_clr) begin
      syn_p   <= '0;
      p_count <= '0;
    end else if (p_shift) begin
      syn_p   <= {syn_p[M-2:0], p_data[6'(63 - p_count)]} ^ (syn_p[M-1] ? P_LOW : '0);
      p_count <= p_count + 1'b1;
    end
  end

  function automatic logic [63:0] pmod(input logic [63:0] v, input logic [63:0] g, input int dg);
    for (int i = 63; i >= dg; i--) if (v[i]) v = v ^ (g << (i - dg));
    return v;
  endfunction

  function automatic logic [63:0] clmul(input logic [63:0] a, input logic [63:0] b);
    logic [63:0] acc;
    acc = '0;
    for (int i = 0; i < 64; i++) if (b[i]) acc = acc ^ (a << i);
    return acc;
  endfunction

  task automatic model(input logic [63:0] cw, output logic [1:0] st,
                       output logic [63:0] co, output logic [5:0] ep);
    logic [63:0] vc, vp, vg, e;
    bit found;
    found = 0;
    vc = pmod(cw, CX, 15);
    vp = pmod(cw, PX, 9);
    st = NOERR; co = cw; ep = '0;
    if (vc == 0 && vp == 0) st = NOERR;
    else if (vc == 0 || vp == 0) st = UNCORR;
    else begin
      st = UNCORR;
      vg = pmod(cw, GX, 24);
      for (int j = 0; j < 64 && !found; j++)
        for (int b = 1; b < 256 && !found; b += 2) begin
          e = 64'(b) << j;
          if ((e >> j) == 64'(b) && pmod(e, GX, 24) == vg) begin
            found = 1; st = CORR; co = cw ^ e; ep = 6'(j);
          end
        end
    end
  endtask

  // Offers one word and waits for the result; ok drops on any expired bound.
  task automatic xfer(input logic [63:0] cw, output logic [1:0] st, output logic [63:0] co,
                      output logic [5:0] ep, output int lat, output bit ok);
    int n;
    ok = 1;
    bus.in_valid = 1'b1;
    bus.cw_in    = cw;
    n = 0;
    while (!bus.in_ready && n < 300) begin @(posedge clk); #1; n++; end
    if (!bus.in_ready) ok = 0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 400) begin @(posedge clk); #1; n++; end
    if (!bus.out_valid) ok = 0;
    lat = n;
    st = bus.status; co = bus.cw_out; ep = bus.err_pos;
  endtask

  task automatic release_out;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready: got %b want 1", bus.in_ready); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); end
    n_cmp++; if (p_clr !== 1'b0) begin n_bad++; $display("FAIL rst_p_clr: got %b want 0", p_clr); end
    n_cmp++; if (p_shift !== 1'b0) begin n_bad++; $display("FAIL rst_p_shift: got %b want 0", p_shift); end
    n_cmp++; if (bus.cw_out !== 64'h0) begin n_bad++; $display("FAIL rst_cw_out: got %h want 0", bus.cw_out); end
    n_cmp++; if (bus.status !== 2'd0) begin n_bad++; $display("FAIL rst_status: got %0d want 0", bus.status); end
    n_cmp++; if (bus.err_pos !== 6'd0) begin n_bad++; $display("FAIL rst_err_pos: got %0d want 0", bus.err_pos); end
    n_cmp++; if (p_data !== 64'h0) begin n_bad++; $display("FAIL rst_p_data: got %h want 0", p_data); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL post_rst_in_ready: got %b want 1", bus.in_ready); end
  endtask

  task automatic test_directed;
    logic [63:0] cws [4];
    logic [1:0]  ests [4];
    logic [63:0] ecos [4];
    logic [5:0]  eeps [4];
    logic [1:0] st; logic [63:0] co; logic [5:0] ep; int lat; bit ok;
    cws[0] = 64'h0;             ests[0] = NOERR;  ecos[0] = 64'h0;   eeps[0] = 6'd0;
    cws[1] = 64'd1 << 37;       ests[1] = CORR;   ecos[1] = 64'h0;   eeps[1] = 6'd37;
    cws[2] = 64'hA5 << 50;      ests[2] = CORR;   ecos[2] = 64'h0;   eeps[2] = 6'd50;
    cws[3] = 64'h211;           ests[3] = UNCORR; ecos[3] = 64'h211; eeps[3] = 6'd0;
    for (int i = 0; i < 4; i++) begin
      xfer(cws[i], st, co, ep, lat, ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL dir%0d_handshake: got timeout want result", i); end
      n_cmp++; if (st !== ests[i]) begin n_bad++; $display("FAIL dir%0d_status: got %0d want %0d", i, st, ests[i]); end
      n_cmp++; if (co !== ecos[i]) begin n_bad++; $display("FAIL dir%0d_cw_out: got %h want %h", i, co, ecos[i]); end
      n_cmp++; if (ep !== eeps[i]) begin n_bad++; $display("FAIL dir%0d_err_pos: got %0d want %0d", i, ep, eeps[i]); end
      release_out();
    end
  endtask

  task automatic test_backpressure;
    logic [1:0] st; logic [63:0] co; logic [5:0] ep; int lat; bit ok;
    xfer(64'd1 << 37, st, co, ep, lat, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL bp_handshake: got timeout want result"); end
    bus.in_valid = 1'b1;
    bus.cw_in    = 64'hFFFF_0000_1234_5678;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_out_valid[%0d]: got %b want 1", i, bus.out_valid); end
      n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, bus.in_ready); end
      n_cmp++; if (p_clr !== 1'b0) begin n_bad++; $display("FAIL bp_p_clr[%0d]: got %b want 0", i, p_clr); end
      n_cmp++; if (bus.status !== CORR) begin n_bad++; $display("FAIL bp_status[%0d]: got %0d want %0d", i, bus.status, CORR); end
      n_cmp++; if (bus.cw_out !== 64'h0) begin n_bad++; $display("FAIL bp_cw_out[%0d]: got %h want 0", i, bus.cw_out); end
      n_cmp++; if (bus.err_pos !== 6'd37) begin n_bad++; $display("FAIL bp_err_pos[%0d]: got %0d want 37", i, bus.err_pos); end
    end
    bus.in_valid = 1'b0;
    release_out();
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_release_out_valid: got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release_in_ready: got %b want 1", bus.in_ready); end
  endtask

  task automatic test_reset_mid_shift;
    logic [1:0] st; logic [63:0] co; logic [5:0] ep; int lat; bit ok; int n;
    bus.in_valid = 1'b1;
    bus.cw_in    = 64'hDEAD_BEEF_0123_4567;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    n = 0;
    while (!p_shift && n < 10) begin @(posedge clk); #1; n++; end
    n_cmp++; if (p_shift !== 1'b1) begin n_bad++; $display("FAIL mid_reach_shift: got %b want 1", p_shift); end
    repeat (20) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL mid_in_ready: got %b want 1", bus.in_ready); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_out_valid: got %b want 0", bus.out_valid); end
    n_cmp++; if (p_shift !== 1'b0) begin n_bad++; $display("FAIL mid_p_shift: got %b want 0", p_shift); end
    n_cmp++; if (p_clr !== 1'b0) begin n_bad++; $display("FAIL mid_p_clr: got %b want 0", p_clr); end
    n_cmp++; if (p_data !== 64'h0) begin n_bad++; $display("FAIL mid_p_data: got %h want 0", p_data); end
    n_cmp++; if (bus.cw_out !== 64'h0) begin n_bad++; $display("FAIL mid_cw_out: got %h want 0", bus.cw_out); end
    n_cmp++; if (bus.status !== 2'd0) begin n_bad++; $display("FAIL mid_status: got %0d want 0", bus.status); end
    n_cmp++; if (bus.err_pos !== 6'd0) begin n_bad++; $display("FAIL mid_err_pos: got %0d want 0", bus.err_pos); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_no_emit[%0d]: got %b want 0", i, bus.out_valid); end
    end
    xfer(64'd1 << 3, st, co, ep, lat, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL mid_next_handshake: got timeout want result"); end
    n_cmp++; if (st !== CORR) begin n_bad++; $display("FAIL mid_next_status: got %0d want %0d", st, CORR); end
    n_cmp++; if (ep !== 6'd3) begin n_bad++; $display("FAIL mid_next_err_pos: got %0d want 3", ep); end
    n_cmp++; if (co !== 64'h0) begin n_bad++; $display("FAIL mid_next_cw_out: got %h want 0", co); end
    release_out();
  endtask

  task automatic test_random;
    logic [63:0] cw, msg, eco, co;
    logic [1:0]  est, st;
    logic [5:0]  eep, ep;
    int lat, len, j; bit ok;
    logic [7:0] b;
    for (int k = 0; k < 40; k++) begin
      msg = {$urandom, $urandom} & ((64'd1 << 40) - 1);
      cw  = msg << 24;
      cw  = cw ^ pmod(cw, GX, 24);
      case (k % 4)
        1, 2: begin
          len = int'($urandom_range(1, 8));
          b   = 8'($urandom_range(0, 255)) & 8'((1 << len) - 1);
          b   = b | 8'd1 | 8'(1 << (len - 1));
          j   = int'($urandom_range(0, 64 - len));
          cw  = cw ^ (64'(b) << j);
        end
        3: cw = {$urandom, $urandom};
        default: ;
      endcase
      model(cw, est, eco, eep);
      xfer(cw, st, co, ep, lat, ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL rnd%0d_handshake: got timeout want result", k); end
      n_cmp++; if (st !== est) begin n_bad++; $display("FAIL rnd%0d_status: cw=%h got %0d want %0d", k, cw, st, est); end
      n_cmp++; if (co !== eco) begin n_bad++; $display("FAIL rnd%0d_cw_out: cw=%h got %h want %h", k, cw, co, eco); end
      n_cmp++; if (ep !== eep) begin n_bad++; $display("FAIL rnd%0d_err_pos: cw=%h got %0d want %0d", k, cw, ep, eep); end
      n_cmp++; if (lat > 160) begin n_bad++; $display("FAIL rnd%0d_latency: got %0d want <=160", k, lat); end
      release_out();
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.cw_in     = '0;
    bus.out_ready = 1'b0;
    CX = (64'd1 << 15) | 64'd1;
    PX = (64'd1 << 9) | 64'(P_LOW);
    GX = clmul(CX, PX);
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_shift();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
